// File: rtl/mem_lsu_pkg.sv
// ---------------------------------------------------------------------------
// mem_lsu_pkg
// Shared definitions for the MEM-stage load/store unit:
//   - access size encodings carried on mem_size
//   - fault codes reported on exc_code
//   - the handshake FSM state type
// ---------------------------------------------------------------------------
package mem_lsu_pkg;

  localparam logic [1:0] SZ_BYTE   = 2'd0;
  localparam logic [1:0] SZ_HALF   = 2'd1;
  localparam logic [1:0] SZ_WORD   = 2'd2;
  localparam logic [1:0] SZ_DOUBLE = 2'd3;

  localparam logic [1:0] EXC_NONE     = 2'd0;
  localparam logic [1:0] EXC_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_TIMEOUT  = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational lane steering for the load/store unit.
// Ports:
//   addr_off_i  byte offset of the access within the data word
//   size_i      access size (byte/half/word/double)
//   uns_i       zero-extend loads when set, sign-extend otherwise
//   wdata_i     right-aligned store data
//   rdata_i     raw data word returned by memory
//   misalign_o  offset is not a multiple of the access size
//   be_o        byte enables for the addressed lane
//   wdata_o     store data replicated across every lane of the access size
//   rdata_o     addressed lane, extended to DATA_W
// ---------------------------------------------------------------------------
module lsu_align
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NB     = DATA_W / 8,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [OFF_W-1:0]  addr_off_i,
  input  logic [1:0]        size_i,
  input  logic              uns_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              misalign_o,
  output logic [NB-1:0]     be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [7:0]        lane_mask;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] val_mask;
  logic              sign_bit;

  always_comb begin
    misalign_o = 1'b0;
    lane_mask  = 8'h01;
    wdata_o    = wdata_i;
    val_mask   = {DATA_W{1'b1}};
    // Bring the addressed lane down to bit 0 before extension.
    shifted    = rdata_i >> {addr_off_i, 3'b000};
    sign_bit   = shifted[DATA_W-1];

    case (size_i)
      SZ_BYTE: begin
        lane_mask = 8'h01;
        wdata_o   = {NB{wdata_i[7:0]}};
        val_mask  = DATA_W'(8'hFF);
        sign_bit  = shifted[7];
      end
      SZ_HALF: begin
        misalign_o = addr_off_i[0];
        lane_mask  = 8'h03;
        wdata_o    = {(NB/2){wdata_i[15:0]}};
        val_mask   = DATA_W'(16'hFFFF);
        sign_bit   = shifted[15];
      end
      SZ_WORD: begin
        misalign_o = (addr_off_i & OFF_W'(3)) != '0;
        lane_mask  = 8'h0F;
        wdata_o    = {(NB/4){wdata_i[31:0]}};
        val_mask   = DATA_W'(32'hFFFF_FFFF);
        sign_bit   = shifted[31];
      end
      default: begin
        // A double access only exists on a 64-bit datapath.
        misalign_o = (DATA_W == 32) ? 1'b1 : ((addr_off_i & OFF_W'(7)) != '0);
        lane_mask  = 8'hFF;
        wdata_o    = wdata_i;
        val_mask   = {DATA_W{1'b1}};
        sign_bit   = shifted[DATA_W-1];
      end
    endcase

    be_o = lane_mask[NB-1:0] << addr_off_i;

    if (uns_i) begin
      rdata_o = shifted & val_mask;
    end else begin
      rdata_o = (shifted & val_mask) | ({DATA_W{sign_bit}} & ~val_mask);
    end
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu
// MEM pipeline stage: branch resolution, load/store unit with a
// variable-latency memory handshake, and the registered MEM/WB register.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid..rd               EX/MEM register contents
//   stall                      hold EX/MEM and earlier stages
//   branch_taken/_addr_out     combinational branch resolution
//   dmem_*                     data-memory request/response
//   wb_*                       registered MEM/WB register
//   exc, exc_code, exc_addr    registered fault pulse and sticky details
// ---------------------------------------------------------------------------
module mem_stage_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic                mem_rd,
  input  logic                mem_wr,
  input  logic                mem_br,
  input  logic [1:0]          mem_size,
  input  logic                mem_uns,
  input  logic [1:0]          wb_ctrl,
  input  logic                zero,
  input  logic [DATA_W-1:0]   alu_res,
  input  logic [DATA_W-1:0]   write_data,
  input  logic [ADDR_W-1:0]   branch_addr,
  input  logic [REG_W-1:0]    rd,
  output logic                stall,
  output logic                branch_taken,
  output logic [ADDR_W-1:0]   branch_addr_out,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [DATA_W/8-1:0] dmem_be,
  output logic [DATA_W-1:0]   dmem_wdata,
  input  logic [DATA_W-1:0]   dmem_rdata,
  input  logic                dmem_ack,
  output logic                wb_valid,
  output logic [1:0]          wb_ctrl_out,
  output logic [DATA_W-1:0]   wb_alu_res,
  output logic [DATA_W-1:0]   wb_read_data,
  output logic [REG_W-1:0]    wb_rd,
  output logic                exc,
  output logic [1:0]          exc_code,
  output logic [ADDR_W-1:0]   exc_addr
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] addr;
  logic              memop;
  logic              is_load;
  logic              misalign;
  logic              req;
  logic              complete;
  logic              timeout;
  logic              misalign_evt;
  logic [DATA_W-1:0] load_ext;

  logic              wb_valid_d;

  assign addr    = alu_res[ADDR_W-1:0];
  assign memop   = in_valid & (mem_rd | mem_wr);
  // Read and write together behaves as a store.
  assign is_load = mem_rd & ~mem_wr;

  assign branch_taken    = in_valid & mem_br & zero;
  assign branch_addr_out = branch_addr;

  lsu_align #(
    .DATA_W (DATA_W),
    .NB     (NB),
    .OFF_W  (OFF_W)
  ) u_align (
    .addr_off_i (addr[OFF_W-1:0]),
    .size_i     (mem_size),
    .uns_i      (mem_uns),
    .wdata_i    (write_data),
    .rdata_i    (dmem_rdata),
    .misalign_o (misalign),
    .be_o       (dmem_be),
    .wdata_o    (dmem_wdata),
    .rdata_o    (load_ext)
  );

  assign dmem_addr = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign dmem_we   = mem_wr;
  // Reset must never leak a request onto the bus.
  assign dmem_req  = req & rst_n;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req          = 1'b0;
    stall        = 1'b0;
    complete     = 1'b0;
    timeout      = 1'b0;
    misalign_evt = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (memop && misalign) begin
          misalign_evt = 1'b1;
        end else if (memop) begin
          req = 1'b1;
          if (dmem_ack) begin
            complete = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_WAIT: begin
        req = 1'b1;
        if (dmem_ack) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
          cnt_d    = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          // Give up: release the pipeline and report the fault.
          timeout = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign wb_valid_d = in_valid & (~memop | complete);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      wb_valid     <= 1'b0;
      wb_ctrl_out  <= '0;
      wb_alu_res   <= '0;
      wb_read_data <= '0;
      wb_rd        <= '0;
      exc          <= 1'b0;
      exc_code     <= EXC_NONE;
      exc_addr     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wb_valid <= wb_valid_d;
      // Bubbles leave the payload fields untouched.
      if (wb_valid_d) begin
        wb_ctrl_out  <= wb_ctrl;
        wb_alu_res   <= alu_res;
        wb_rd        <= rd;
        wb_read_data <= (memop && is_load) ? load_ext : '0;
      end
      exc <= misalign_evt | timeout;
      if (misalign_evt) begin
        exc_code <= EXC_MISALIGN;
        exc_addr <= addr;
      end else if (timeout) begin
        exc_code <= EXC_TIMEOUT;
        exc_addr <= addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 5;
  localparam int TO = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid, mem_rd, mem_wr, mem_br, mem_uns, zero;
  logic [1:0]    mem_size, wb_ctrl;
  logic [DW-1:0] alu_res, write_data, dmem_rdata;
  logic [AW-1:0] branch_addr;
  logic [RW-1:0] rd;
  logic          dmem_ack;
  logic          stall, branch_taken, dmem_req, dmem_we;
  logic [AW-1:0] branch_addr_out, dmem_addr, exc_addr;
  logic [3:0]    dmem_be;
  logic [DW-1:0] dmem_wdata, wb_alu_res, wb_read_data;
  logic          wb_valid, exc;
  logic [1:0]    wb_ctrl_out, exc_code;
  logic [RW-1:0] wb_rd;

  int errors = 0;
  int checks = 0;

  mem_stage_lsu #(
    .DATA_W (DW), .ADDR_W (AW), .REG_W (RW), .TIMEOUT (TO)
  ) dut (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .mem_rd (mem_rd),
    .mem_wr (mem_wr), .mem_br (mem_br), .mem_size (mem_size),
    .mem_uns (mem_uns), .wb_ctrl (wb_ctrl), .zero (zero),
    .alu_res (alu_res), .write_data (write_data),
    .branch_addr (branch_addr), .rd (rd), .stall (stall),
    .branch_taken (branch_taken), .branch_addr_out (branch_addr_out),
    .dmem_req (dmem_req), .dmem_we (dmem_we), .dmem_addr (dmem_addr),
    .dmem_be (dmem_be), .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata), .dmem_ack (dmem_ack),
    .wb_valid (wb_valid), .wb_ctrl_out (wb_ctrl_out),
    .wb_alu_res (wb_alu_res), .wb_read_data (wb_read_data),
    .wb_rd (wb_rd), .exc (exc), .exc_code (exc_code), .exc_addr (exc_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    in_valid = 0; mem_rd = 0; mem_wr = 0; mem_br = 0; mem_uns = 0;
    zero = 0; mem_size = 2'd2; wb_ctrl = 2'd0; alu_res = '0;
    write_data = '0; branch_addr = '0; rd = '0; dmem_rdata = '0;
    dmem_ack = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
    checks++; if (exc !== 1'b0 || exc_code !== 2'd0) begin errors++; $display("FAIL reset_exc got=%b/%0d exp=0/0", exc, exc_code); end
    checks++; if (wb_alu_res !== 32'h0 || exc_addr !== 32'h0) begin errors++; $display("FAIL reset_regs got=%h/%h exp=0/0", wb_alu_res, exc_addr); end
    rst_n = 1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_zero_wait();
    // sw 0xDEADBEEF @0x104, ack in the same cycle
    idle_inputs();
    in_valid = 1; mem_wr = 1; mem_size = 2'd2; alu_res = 32'h104;
    write_data = 32'hDEADBEEF; rd = 5'd3; wb_ctrl = 2'b01; dmem_ack = 1;
    @(negedge clk);
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL sw_handshake got req=%b we=%b stall=%b exp=1 1 0", dmem_req, dmem_we, stall); end
    checks++; if (dmem_be !== 4'b1111 || dmem_addr !== 32'h104 || dmem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_lanes got be=%b addr=%h wd=%h exp=1111 104 deadbeef", dmem_be, dmem_addr, dmem_wdata); end
    tick();
    checks++; if (wb_valid !== 1'b1 || wb_read_data !== 32'h0 || wb_alu_res !== 32'h104) begin errors++; $display("FAIL sw_wb got v=%b rdat=%h alu=%h exp=1 0 104", wb_valid, wb_read_data, wb_alu_res); end
    // lw @0x104 returning the stored value
    mem_wr = 0; mem_rd = 1; rd = 5'd7; wb_ctrl = 2'b11; dmem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL lw_handshake got req=%b we=%b stall=%b exp=1 0 0", dmem_req, dmem_we, stall); end
    tick();
    checks++; if (wb_valid !== 1'b1 || wb_read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_wb got v=%b rdat=%h exp=1 deadbeef", wb_valid, wb_read_data); end
    checks++; if (wb_rd !== 5'd7 || wb_ctrl_out !== 2'b11) begin errors++; $display("FAIL lw_fields got rd=%0d ctrl=%b exp=7 11", wb_rd, wb_ctrl_out); end
    idle_inputs();
    tick();
    checks++; if (wb_valid !== 1'b0 || wb_read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bubble_hold got v=%b rdat=%h exp=0 deadbeef", wb_valid, wb_read_data); end
    $display("test_zero_wait done");
  endtask

  task automatic test_byte_half();
    idle_inputs();
    in_valid = 1; mem_rd = 1; mem_size = 2'd0; alu_res = 32'h103;
    dmem_rdata = 32'h80123456; dmem_ack = 1;
    @(negedge clk);
    checks++; if (dmem_be !== 4'b1000 || dmem_addr !== 32'h100) begin errors++; $display("FAIL lb_lanes got be=%b addr=%h exp=1000 100", dmem_be, dmem_addr); end
    tick();
    checks++; if (wb_read_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed got=%h exp=ffffff80", wb_read_data); end
    mem_uns = 1;
    tick();
    checks++; if (wb_read_data !== 32'h00000080) begin errors++; $display("FAIL lbu got=%h exp=00000080", wb_read_data); end
    mem_uns = 0; mem_size = 2'd1; alu_res = 32'h102;
    tick();
    checks++; if (wb_read_data !== 32'hFFFF8012) begin errors++; $display("FAIL lh_signed got=%h exp=ffff8012", wb_read_data); end
    mem_rd = 0; mem_wr = 1; mem_size = 2'd0; write_data = 32'h0000005A;
    @(negedge clk);
    checks++; if (dmem_be !== 4'b0100 || dmem_wdata !== 32'h5A5A5A5A) begin errors++; $display("FAIL sb_lanes got be=%b wd=%h exp=0100 5a5a5a5a", dmem_be, dmem_wdata); end
    mem_size = 2'd1; alu_res = 32'h102; write_data = 32'h0000BEEF;
    @(negedge clk);
    checks++; if (dmem_be !== 4'b1100 || dmem_wdata !== 32'hBEEFBEEF) begin errors++; $display("FAIL sh_lanes got be=%b wd=%h exp=1100 beefbeef", dmem_be, dmem_wdata); end
    tick();
    idle_inputs();
    tick();
    $display("test_byte_half done");
  endtask

  task automatic test_wait3();
    int stall_cnt = 0, req_cnt = 0, req_edges = 0, wb_pulses = 0;
    logic prev_req = 0;
    idle_inputs();
    in_valid = 1; mem_rd = 1; mem_size = 2'd2; alu_res = 32'h200;
    dmem_rdata = 32'h11223344; rd = 5'd9;
    for (int c = 0; c < 7; c++) begin
      dmem_ack = (c == 3);
      if (c > 3) idle_inputs();
      @(negedge clk);
      if (stall) stall_cnt++;
      if (dmem_req) req_cnt++;
      if (dmem_req && !prev_req) req_edges++;
      prev_req = dmem_req;
      tick();
      if (wb_valid) begin
        wb_pulses++;
        checks++; if (wb_read_data !== 32'h11223344 || c != 3) begin errors++; $display("FAIL wait3_data got=%h at c=%0d exp=11223344 at c=3", wb_read_data, c); end
      end
    end
    checks++; if (stall_cnt != 3) begin errors++; $display("FAIL wait3_stall got=%0d exp=3", stall_cnt); end
    checks++; if (req_cnt != 4 || req_edges != 1) begin errors++; $display("FAIL wait3_req got cycles=%0d bursts=%0d exp=4 1", req_cnt, req_edges); end
    checks++; if (wb_pulses != 1) begin errors++; $display("FAIL wait3_wb got=%0d exp=1", wb_pulses); end
    $display("test_wait3 done");
  endtask

  task automatic test_timeout();
    int stall_cnt = 0;
    bit dropped = 0;
    idle_inputs();
    in_valid = 1; mem_wr = 1; mem_size = 2'd2; alu_res = 32'h300;
    for (int c = 0; c < 40 && !dropped; c++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      else dropped = 1;
      if (!dropped) tick();
    end
    checks++; if (!dropped || stall_cnt != TO) begin errors++; $display("FAIL timeout_stall got dropped=%0d cycles=%0d exp=1 %0d", dropped, stall_cnt, TO); end
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL timeout_req got=%b exp=1", dmem_req); end
    tick();
    checks++; if (exc !== 1'b1 || exc_code !== 2'd2 || exc_addr !== 32'h300) begin errors++; $display("FAIL timeout_exc got=%b/%0d/%h exp=1/2/300", exc, exc_code, exc_addr); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL timeout_wb got=%b exp=0", wb_valid); end
    idle_inputs();
    tick();
    checks++; if (exc !== 1'b0 || exc_code !== 2'd2) begin errors++; $display("FAIL timeout_pulse got=%b/%0d exp=0/2", exc, exc_code); end
    $display("test_timeout done");
  endtask

  task automatic test_misalign_branch();
    idle_inputs();
    in_valid = 1; mem_rd = 1; mem_size = 2'd1; alu_res = 32'h101; dmem_ack = 1;
    @(negedge clk);
    checks++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL mis_req got req=%b stall=%b exp=0 0", dmem_req, stall); end
    tick();
    checks++; if (exc !== 1'b1 || exc_code !== 2'd1 || exc_addr !== 32'h101 || wb_valid !== 1'b0) begin errors++; $display("FAIL mis_exc got=%b/%0d/%h v=%b exp=1/1/101 v=0", exc, exc_code, exc_addr, wb_valid); end
    idle_inputs();
    in_valid = 1; mem_br = 1; zero = 1; branch_addr = 32'h400; alu_res = 32'h0;
    @(negedge clk);
    checks++; if (branch_taken !== 1'b1 || branch_addr_out !== 32'h400 || dmem_req !== 1'b0) begin errors++; $display("FAIL beq got taken=%b tgt=%h req=%b exp=1 400 0", branch_taken, branch_addr_out, dmem_req); end
    tick();
    checks++; if (wb_valid !== 1'b1 || exc !== 1'b0 || exc_code !== 2'd1) begin errors++; $display("FAIL beq_wb got v=%b exc=%b code=%0d exp=1 0 1", wb_valid, exc, exc_code); end
    zero = 0;
    @(negedge clk);
    checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL bne got taken=%b exp=0", branch_taken); end
    idle_inputs();
    tick();
    $display("test_misalign_branch done");
  endtask

  task automatic test_reset_wait();
    idle_inputs();
    in_valid = 1; mem_rd = 1; mem_size = 2'd2; alu_res = 32'h500; rd = 5'd4;
    tick();           // IDLE -> WAIT
    tick();           // WAIT cycle 1
    rst_n = 0;        // WAIT cycle 2
    @(negedge clk);
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rstwait_req got=%b exp=0", dmem_req); end
    tick();
    checks++; if (wb_valid !== 1'b0 || exc !== 1'b0 || exc_code !== 2'd0 || exc_addr !== 32'h0 || wb_read_data !== 32'h0 || wb_rd !== 5'd0) begin errors++; $display("FAIL rstwait_regs got v=%b exc=%b code=%0d addr=%h rdat=%h rd=%0d exp=all 0", wb_valid, exc, exc_code, exc_addr, wb_read_data, wb_rd); end
    rst_n = 1;
    idle_inputs();
    @(negedge clk);
    checks++; if (stall !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL rstwait_idle got stall=%b req=%b exp=0 0", stall, dmem_req); end
    tick();
    checks++; if (exc !== 1'b0) begin errors++; $display("FAIL rstwait_exc got=%b exp=0", exc); end
    $display("test_reset_wait done");
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_byte_half();
    test_wait3();
    test_timeout();
    test_misalign_branch();
    test_reset_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
